// File: rtl/and4_response_checker.sv
// Response checker for the AND4 cell: compares each sampled output with the ideal 4-input AND,
// counts vectors and mismatches, captures the first failing vector and gives a pass/fail verdict.
// Optional MISR signature built when AND4_CHECKER_MISR_EN is defined.
module and4_response_checker #(
  parameter int NUM_VECTORS = 8,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  input  logic [3:0]       vec,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [3:0]       first_fail_vec,
  output logic [7:0]       signature
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] vec_count_q, vec_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             ff_valid_q, ff_valid_d;
  logic [3:0]       ff_vec_q, ff_vec_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             mismatch_s;

`ifdef AND4_CHECKER_MISR_EN
  logic [7:0] sig_q, sig_d;

  // One MISR step over x^8+x^4+x^3+x^2+1, folding in {vec, dut_out}.
  function automatic logic [7:0] misr_step(input logic [7:0] sig, input logic [3:0] v,
                                           input logic o);
    misr_step = {sig[6:0], 1'b0} ^ (sig[7] ? 8'h1D : 8'h00) ^ {3'b000, v, o};
  endfunction
`endif

  // Next-state, counter, capture and verdict logic.
  always_comb begin
    state_d     = state_q;
    vec_count_d = vec_count_q;
    err_count_d = err_count_q;
    ff_valid_d  = ff_valid_q;
    ff_vec_d    = ff_vec_q;
`ifdef AND4_CHECKER_MISR_EN
    sig_d       = sig_q;
`endif
    mismatch_s  = (dut_out != (&vec));

    case (state_q)
      S_IDLE, S_DONE: begin
        // A sample arriving with start is intentionally dropped.
        if (start) begin
          state_d     = S_RUN;
          vec_count_d = {CNT_W{1'b0}};
          err_count_d = {CNT_W{1'b0}};
          ff_valid_d  = 1'b0;
          ff_vec_d    = 4'b0000;
`ifdef AND4_CHECKER_MISR_EN
          sig_d       = 8'h00;
`endif
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        if (vec_valid) begin
          vec_count_d = vec_count_q + CNT_W'(1);
          if (mismatch_s) begin
            err_count_d = err_count_q + CNT_W'(1);
            if (!ff_valid_q) begin
              ff_valid_d = 1'b1;
              ff_vec_d   = vec;
            end else begin
              ff_valid_d = ff_valid_q;
            end
          end else begin
            err_count_d = err_count_q;
          end
`ifdef AND4_CHECKER_MISR_EN
          sig_d = misr_step(sig_q, vec, dut_out);
`endif
          if (vec_count_d == CNT_W'(NUM_VECTORS)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
    pass_d = (state_d == S_DONE) && (err_count_d == {CNT_W{1'b0}});
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vec_count_q <= {CNT_W{1'b0}};
      err_count_q <= {CNT_W{1'b0}};
      ff_valid_q  <= 1'b0;
      ff_vec_q    <= 4'b0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_count_q <= vec_count_d;
      err_count_q <= err_count_d;
      ff_valid_q  <= ff_valid_d;
      ff_vec_q    <= ff_vec_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

`ifdef AND4_CHECKER_MISR_EN
  // Signature register, seeded on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= 8'h00;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign signature = sig_q;
`else
  assign signature = 8'h00;
`endif

  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign vec_count        = vec_count_q;
  assign err_count        = err_count_q;
  assign first_fail_valid = ff_valid_q;
  assign first_fail_vec   = ff_vec_q;

endmodule

// File: tb/tb_and4_response_checker.sv
// Self-checking bench for and4_response_checker: behavioural model compared every cycle,
// directed golden/fault/gap/reset runs with literal expectations, then random traffic.
module tb_and4_response_checker;
  localparam int NV = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, start, vec_valid, dut_out;
  logic [3:0]    vec;
  logic          busy, done, pass, first_fail_valid;
  logic [CW-1:0] vec_count, err_count;
  logic [3:0]    first_fail_vec;
  logic [7:0]    signature;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Behavioural model
  bit         m_run   = 1'b0;
  bit         m_fin   = 1'b0;
  int         m_vc    = 0;
  int         m_ec    = 0;
  bit         m_ffv   = 1'b0;
  logic [3:0] m_ffvec = 4'b0000;
  logic [7:0] m_sig   = 8'h00;

  logic [3:0] gold [8] = '{4'b0000, 4'b1111, 4'b1011, 4'b0100,
                           4'b0010, 4'b1101, 4'b1001, 4'b0111};

  and4_response_checker #(.NUM_VECTORS(NV), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec(vec),
    .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
    .vec_count(vec_count), .err_count(err_count),
    .first_fail_valid(first_fail_valid), .first_fail_vec(first_fail_vec),
    .signature(signature)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gf_mul_x_add(input logic [7:0] s, input logic [7:0] d);
    logic [7:0] r;
    r = s << 1;
    if (s[7]) r = r ^ 8'h1D;
    return r ^ d;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at each rising edge
  always @(posedge clk) begin
    if (rst) begin
      m_run <= 1'b0; m_fin <= 1'b0; m_vc <= 0; m_ec <= 0;
      m_ffv <= 1'b0; m_ffvec <= 4'b0000; m_sig <= 8'h00;
    end else if (!m_run) begin
      if (start) begin
        m_run <= 1'b1; m_fin <= 1'b0; m_vc <= 0; m_ec <= 0;
        m_ffv <= 1'b0; m_ffvec <= 4'b0000; m_sig <= 8'h00;
      end
    end else if (vec_valid) begin
      m_vc <= m_vc + 1;
      if (dut_out != (vec == 4'b1111)) begin
        m_ec <= m_ec + 1;
        if (!m_ffv) begin
          m_ffv   <= 1'b1;
          m_ffvec <= vec;
        end
      end
      m_sig <= gf_mul_x_add(m_sig, {3'b000, vec, dut_out});
      if (m_vc + 1 == NV) begin
        m_run <= 1'b0;
        m_fin <= 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_run));
      check("done", 32'(done), 32'(m_fin));
      check("pass", 32'(pass), 32'(m_fin && (m_ec == 0)));
      check("vec_count", 32'(vec_count), 32'(m_vc));
      check("err_count", 32'(err_count), 32'(m_ec));
      check("first_fail_valid", 32'(first_fail_valid), 32'(m_ffv));
      check("first_fail_vec", 32'(first_fail_vec), 32'(m_ffvec));
`ifdef AND4_CHECKER_MISR_EN
      check("signature", 32'(signature), 32'(m_sig));
`else
      check("signature", 32'(signature), 32'h0);
`endif
    end
  end

  task automatic step(input logic r, input logic s, input logic vv, input logic [3:0] v,
                      input logic o);
    rst = r; start = s; vec_valid = vv; vec = v; dut_out = o;
    @(posedge clk);
    #2;
  endtask

  // mode 0: golden, 1: injected fault on 1011/0111, 2: stuck-at-0
  task automatic run(input int mode, input int gap, input bit start_in_gap);
    logic [3:0] v;
    logic       o;
    step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 8; i++) begin
      v = gold[i];
      case (mode)
        0: o = (v == 4'b1111);
        1: o = (v == 4'b1111) || (v == 4'b1011) || (v == 4'b0111);
        default: o = 1'b0;
      endcase
      step(1'b0, 1'b0, 1'b1, v, o);
      if (i < 7) begin
        for (int g = 0; g < gap; g++) begin
          step(1'b0, start_in_gap && (i == 3) && (g == 0), 1'b0,
               4'($urandom), 1'($urandom));
          if (start_in_gap && (i == 3) && (g == 0))
            check("start_in_run_ignored", 32'(vec_count), 32'd4);
        end
      end
    end
  endtask

  logic [7:0] sig_a, sig_b, sig_f;

  initial begin
    rst = 1'b1; start = 1'b0; vec_valid = 1'b0; vec = 4'b0000; dut_out = 1'b0;
    @(posedge clk);
    #2;
    chk_en = 1'b1;
    step(1'b1, 1'b1, 1'b1, 4'b1111, 1'b0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_vec_count", 32'(vec_count), 32'd0);
    check("reset_signature", 32'(signature), 32'h00);

    run(0, 0, 1'b0);
    check("golden_done", 32'(done), 32'd1);
    check("golden_vec_count", 32'(vec_count), 32'd8);
    check("golden_err_count", 32'(err_count), 32'd0);
    check("golden_pass", 32'(pass), 32'd1);
    check("golden_ffv", 32'(first_fail_valid), 32'd0);
    sig_a = signature;
    run(0, 0, 1'b0);
    check("golden2_pass", 32'(pass), 32'd1);
    sig_b = signature;

    run(1, 0, 1'b0);
    check("fault_err_count", 32'(err_count), 32'd2);
    check("fault_ffvec", 32'(first_fail_vec), 32'hB);
    check("fault_ffv", 32'(first_fail_valid), 32'd1);
    check("fault_pass", 32'(pass), 32'd0);
    sig_f = signature;
`ifdef AND4_CHECKER_MISR_EN
    check("sig_repeatable", 32'(sig_a), 32'(sig_b));
    check("sig_nonzero", 32'(sig_a != 8'h00), 32'd1);
    check("sig_fault_differs", 32'(sig_f != sig_a), 32'd1);
`else
    check("sig_zero_golden", 32'(sig_a | sig_b), 32'h0);
    check("sig_zero_fault", 32'(sig_f), 32'h0);
`endif

    run(2, 0, 1'b0);
    check("stuck_err_count", 32'(err_count), 32'd1);
    check("stuck_ffvec", 32'(first_fail_vec), 32'hF);
    check("stuck_pass", 32'(pass), 32'd0);

    run(0, 2, 1'b1);
    check("gap_done", 32'(done), 32'd1);
    check("gap_vec_count", 32'(vec_count), 32'd8);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 4'b0101, 1'b1);
    check("done_hold_vec_count", 32'(vec_count), 32'd8);
    check("done_hold_err_count", 32'(err_count), 32'd0);
    check("done_hold_pass", 32'(pass), 32'd1);

    step(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'b0001, 1'b0);
    check("midrun_count", 32'(vec_count), 32'd3);
    step(1'b1, 1'b0, 1'b1, 4'b1111, 1'b0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_vec_count", 32'(vec_count), 32'd0);
    check("midrst_err_count", 32'(err_count), 32'd0);
    check("midrst_ffv", 32'(first_fail_valid), 32'd0);
    check("midrst_ffvec", 32'(first_fail_vec), 32'h0);
    check("midrst_sig", 32'(signature), 32'h00);
    run(0, 0, 1'b0);
    check("post_rst_pass", 32'(pass), 32'd1);

    for (int n = 0; n < 400; n++) begin
      logic [3:0] v;
      v = 4'($urandom);
      step($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0, v,
           (v == 4'b1111) ^ ($urandom_range(0, 7) == 0));
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
